// File: rtl/blink64_inv_diffusion_engine_if.sv
// Block-level handshake bundle for the Blink-64 inverse-diffusion engine.
// The master side feeds blocks and drains results; the slave side is the engine.
interface blink64_inv_diffusion_engine_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic [63:0] in_rk;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        busy;

    modport master (
        output in_valid, in_data, in_rk, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_rk, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/blink64_inv_diffusion_engine.sv
// Blink-64 inverse diffusion: optional round-key add at capture, then one
// 16-bit column per cycle is replaced by its "XOR of the other three nibbles"
// image. Column c gathers nibbles c, 4+c, 8+c and 12+c of the block.
module blink64_inv_diffusion_engine #(
    parameter bit KEY_ADD = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    blink64_inv_diffusion_engine_if.slave       bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        DONE    = 2'd2
    } fsm_t;

    fsm_t        fsm_reg;
    logic [1:0]  col_reg;
    logic [63:0] blk_reg;
    logic        in_ready_reg;
    logic        out_valid_reg;
    logic        busy_reg;

    logic [63:0]      blk_next;
    logic [63:0]      capture;
    logic [3:0][3:0]  parity;

    genvar gi;

    // Column parities; each nibble XORed with its parity yields the XOR of
    // the other three nibbles of that column.
    generate
        for (gi = 0; gi < 4; gi++) begin : g_parity
            assign parity[gi] = blk_reg[4*gi +: 4]      ^ blk_reg[4*(gi+4) +: 4] ^
                                blk_reg[4*(gi+8) +: 4]  ^ blk_reg[4*(gi+12) +: 4];
        end

        // Only nibbles belonging to the selected column change this cycle.
        for (gi = 0; gi < 16; gi++) begin : g_nibble
            assign blk_next[4*gi +: 4] = (col_reg == 2'(gi % 4))
                                       ? (blk_reg[4*gi +: 4] ^ parity[gi % 4])
                                       : blk_reg[4*gi +: 4];
        end

        if (KEY_ADD) begin : g_key_add
            assign capture = bus.in_data ^ bus.in_rk;
        end else begin : g_no_key_add
            assign capture = bus.in_data;
        end
    endgenerate

    // Control FSM with registered handshake outputs; the datapath register
    // doubles as the output register so out_data is stable throughout DONE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_reg       <= IDLE;
            col_reg       <= 2'd0;
            blk_reg       <= 64'h0;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            case (fsm_reg)
                IDLE: begin
                    if (bus.in_valid && in_ready_reg) begin
                        blk_reg      <= capture;
                        col_reg      <= 2'd0;
                        fsm_reg      <= COMPUTE;
                        in_ready_reg <= 1'b0;
                        busy_reg     <= 1'b1;
                    end
                end
                COMPUTE: begin
                    blk_reg <= blk_next;
                    col_reg <= col_reg + 2'd1;
                    if (col_reg == 2'd3) begin
                        fsm_reg       <= DONE;
                        out_valid_reg <= 1'b1;
                    end
                end
                DONE: begin
                    // No capture here even if in_valid is high: the next block
                    // is only taken once the engine is back in IDLE.
                    if (out_valid_reg && bus.out_ready) begin
                        fsm_reg       <= IDLE;
                        out_valid_reg <= 1'b0;
                        in_ready_reg  <= 1'b1;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    fsm_reg       <= IDLE;
                    col_reg       <= 2'd0;
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = blk_reg;
    assign bus.busy      = busy_reg;

endmodule
